// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the C64 video path (write and read agents).
package fb_pkg;
  localparam int C64_W        = 504;
  localparam int C64_H        = 312;
  localparam int PIX_PER_WORD = 4;
  localparam int FRAME_WORDS  = C64_W * C64_H / PIX_PER_WORD;

  typedef logic [3:0] color_t;

  typedef enum logic {ST_IDLE, ST_REQ} wr_state_t;
endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_ff2 (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/fb_write_agent.sv
// Drains packed pixel words from the show-ahead write FIFO into SDRAM,
// double-buffering frames on vsync and publishing the last complete buffer.
module fb_write_agent #(
  parameter int ADDR_W      = 17,
  parameter int FRAME_WORDS = fb_pkg::FRAME_WORDS,
  parameter int FCNT_W      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_vsync,
  input  logic              i_fifo_empty,
  input  logic [15:0]       i_fifo_rdata,
  output logic              o_fifo_rd,
  output logic              o_wr_req,
  input  logic              i_wr_gnt,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_front_buf,
  output logic              o_frame_done,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_short_frame,
  output logic              o_overrun,
  input  logic              i_clr_status
);
  import fb_pkg::*;

  localparam int              OFF_W = ADDR_W - 1;
  localparam logic [OFF_W-1:0] FULL = OFF_W'(FRAME_WORDS);

  wr_state_t        state;
  logic             vs_s, vs_d, vs_pend, vs_rise;
  logic             back_buf;
  logic [OFF_W-1:0] offset;
  logic [OFF_W:0]   offset_inc;
  logic             at_full, has_room, chain, idle_pop, take, drop_over;
  logic             boundary, short_set;

  sync_ff2 u_vs_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (i_vsync),
    .q      (vs_s)
  );

  assign vs_rise    = vs_s & ~vs_d;
  assign offset_inc = {1'b0, offset} + (OFF_W + 1)'(1);
  assign at_full    = (offset == FULL);
  assign has_room   = (offset_inc < {1'b0, FULL});

  // A pending vsync blocks both idle pops and chaining so the boundary lands
  // between words, never inside an outstanding request.
  assign idle_pop  = (state == ST_IDLE) & ~vs_pend & ~i_fifo_empty;
  assign chain     = (state == ST_REQ) & i_wr_gnt & ~i_fifo_empty & ~vs_pend & ~vs_s & has_room;
  assign drop_over = idle_pop & ~vs_s & at_full;
  assign take      = (idle_pop & ~vs_s & ~at_full) | chain;
  assign o_fifo_rd = resetn & (idle_pop | chain);

  assign boundary  = (state == ST_IDLE) & vs_pend;
  assign short_set = boundary & ~at_full;
  assign o_wr_addr = {back_buf, offset};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      o_wr_req     <= 1'b0;
      o_wr_data    <= '0;
      back_buf     <= 1'b0;
      o_front_buf  <= 1'b1;
      offset       <= '0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      vs_d         <= 1'b0;
      vs_pend      <= 1'b0;
    end else begin
      vs_d         <= vs_s;
      o_frame_done <= 1'b0;
      if (vs_rise)
        vs_pend <= 1'b1;
      else if (boundary)
        vs_pend <= 1'b0;
      if (take)
        o_wr_data <= i_fifo_rdata;
      case (state)
        ST_IDLE: begin
          if (vs_pend) begin
            if (at_full) begin
              o_front_buf  <= back_buf;
              back_buf     <= ~back_buf;
              o_frame_done <= 1'b1;
              o_frame_cnt  <= o_frame_cnt + FCNT_W'(1);
            end
            offset <= '0;
          end else if (take) begin
            state    <= ST_REQ;
            o_wr_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_wr_gnt) begin
            if (!at_full)
              offset <= offset_inc[OFF_W-1:0];
            if (!chain) begin
              state    <= ST_IDLE;
              o_wr_req <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_short_frame <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      if (short_set)
        o_short_frame <= 1'b1;
      else if (i_clr_status)
        o_short_frame <= 1'b0;
      if (drop_over)
        o_overrun <= 1'b1;
      else if (i_clr_status)
        o_overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fb_write_agent.sv
// Directed bench for fb_write_agent with a show-ahead FIFO model and SDRAM grant driver.
`timescale 1ns/1ps
module tb_fb_write_agent;
  localparam int FW = 39312;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_fifo_empty;
  logic [15:0] i_fifo_rdata;
  logic        o_fifo_rd;
  logic        o_wr_req;
  logic        i_wr_gnt = 1'b0;
  logic [16:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic        o_front_buf;
  logic        o_frame_done;
  logic [7:0]  o_frame_cnt;
  logic        o_short_frame;
  logic        o_overrun;
  logic        i_clr_status = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] wp = 16'd0;
  logic [15:0] rp = 16'd0;

  assign i_fifo_empty = (wp == rp);
  assign i_fifo_rdata = mem[rp];

  always @(posedge clk) if (o_fifo_rd) rp <= rp + 16'd1;

  always #4 clk = ~clk;

  fb_write_agent dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_vsync       (i_vsync),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_rdata  (i_fifo_rdata),
    .o_fifo_rd     (o_fifo_rd),
    .o_wr_req      (o_wr_req),
    .i_wr_gnt      (i_wr_gnt),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_front_buf   (o_front_buf),
    .o_frame_done  (o_frame_done),
    .o_frame_cnt   (o_frame_cnt),
    .o_short_frame (o_short_frame),
    .o_overrun     (o_overrun),
    .i_clr_status  (i_clr_status)
  );

  function automatic logic [15:0] pat(input int k);
    return 16'(k * 3 + 1) ^ 16'hA5C3;
  endfunction

  task automatic push(input logic [15:0] v);
    mem[wp] = v;
    wp = wp + 16'd1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; i_wr_gnt = 1'b0; i_vsync = 1'b0; i_clr_status = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; i_wr_gnt = 1'b0; i_vsync = 1'b0; i_clr_status = 1'b0;
    repeat (2) @(negedge clk);
    push(16'h1234);
    #1;
    n_cmp++; if (o_fifo_rd !== 1'b0) begin n_err++; $display("FAIL reset_no_pop got=%b want=0", o_fifo_rd); end
    n_cmp++; if (o_front_buf !== 1'b1) begin n_err++; $display("FAIL reset_front got=%b want=1", o_front_buf); end
    n_cmp++; if ({o_wr_req, o_wr_addr, o_wr_data, o_frame_done, o_frame_cnt, o_short_frame, o_overrun} !== 45'd0) begin
      n_err++; $display("FAIL reset_zero got req=%b addr=%h data=%h done=%b cnt=%0d short=%b over=%b want all 0",
        o_wr_req, o_wr_addr, o_wr_data, o_frame_done, o_frame_cnt, o_short_frame, o_overrun); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (o_wr_req !== 1'b1) begin n_err++; $display("FAIL first_req got=%b want=1", o_wr_req); end
    n_cmp++; if (o_wr_addr !== 17'h00000) begin n_err++; $display("FAIL first_addr got=%h want=00000", o_wr_addr); end
    n_cmp++; if (o_wr_data !== 16'h1234) begin n_err++; $display("FAIL first_data got=%h want=1234", o_wr_data); end
    @(negedge clk);
    n_cmp++; if (o_wr_req !== 1'b1) begin n_err++; $display("FAIL req_held got=%b want=1", o_wr_req); end
    i_wr_gnt = 1'b1;
    #1;
    n_cmp++; if (o_fifo_rd !== 1'b0) begin n_err++; $display("FAIL pop_when_empty got=%b want=0", o_fifo_rd); end
    @(negedge clk); i_wr_gnt = 1'b0;
    n_cmp++; if (o_wr_req !== 1'b0) begin n_err++; $display("FAIL req_drop got=%b want=0", o_wr_req); end
    n_cmp++; if (o_wr_addr !== 17'h00001) begin n_err++; $display("FAIL offset_inc got=%h want=00001", o_wr_addr); end
  endtask

  task automatic test_complete_frame();
    int k, bad, bk, dones;
    logic [16:0] ba;
    logic front_at, found;
    do_reset();
    for (int i = 0; i < FW; i++) push(pat(i));
    i_wr_gnt = 1'b1;
    k = 0; bad = 0; bk = 0; ba = '0;
    for (int c = 0; c < FW + 100 && k < FW; c++) begin
      @(negedge clk);
      if (o_wr_req) begin
        if (o_wr_addr !== 17'(k) || o_wr_data !== pat(k)) begin
          if (bad == 0) begin bk = k; ba = o_wr_addr; end
          bad++;
        end
        k++;
      end
    end
    n_cmp++; if (k !== FW) begin n_err++; $display("FAIL frame_words got=%0d want=%0d", k, FW); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL frame_seq bad=%0d first word %0d addr=%h want bad=0", bad, bk, ba); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({o_wr_req, o_overrun, o_frame_done} !== 3'b000) begin
      n_err++; $display("FAIL frame_end got req/over/done=%b want 000", {o_wr_req, o_overrun, o_frame_done}); end
    i_vsync = 1'b1; dones = 0; front_at = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) i_vsync = 1'b0;
      if (o_frame_done) begin dones++; front_at = o_front_buf; end
    end
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL done_pulses got=%0d want=1", dones); end
    n_cmp++; if (front_at !== 1'b0) begin n_err++; $display("FAIL front_at_done got=%b want=0", front_at); end
    n_cmp++; if (o_frame_cnt !== 8'd1) begin n_err++; $display("FAIL frame_cnt got=%0d want=1", o_frame_cnt); end
    n_cmp++; if (o_short_frame !== 1'b0) begin n_err++; $display("FAIL full_not_short got=%b want=0", o_short_frame); end
    push(16'hBEEF); found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin @(negedge clk); if (o_wr_req) found = 1'b1; end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL next_frame_req timeout got=%b want=1", found); end
    n_cmp++; if (o_wr_addr !== 17'h10000) begin n_err++; $display("FAIL next_frame_addr got=%h want=10000", o_wr_addr); end
    @(negedge clk);
  endtask

  task automatic test_short_frame();
    int reqs, dones;
    logic found;
    do_reset();
    for (int i = 0; i < 100; i++) push(pat(i + 7));
    i_wr_gnt = 1'b1; reqs = 0;
    for (int c = 0; c < 120; c++) begin @(negedge clk); if (o_wr_req) reqs++; end
    n_cmp++; if (reqs !== 100) begin n_err++; $display("FAIL short_words got=%0d want=100", reqs); end
    i_vsync = 1'b1; dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) i_vsync = 1'b0;
      if (o_frame_done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL short_no_done got=%0d want=0", dones); end
    n_cmp++; if (o_short_frame !== 1'b1) begin n_err++; $display("FAIL short_flag got=%b want=1", o_short_frame); end
    n_cmp++; if ({o_front_buf, o_frame_cnt} !== 9'h100) begin
      n_err++; $display("FAIL short_front_cnt got front=%b cnt=%0d want front=1 cnt=0", o_front_buf, o_frame_cnt); end
    push(16'h0F0F); found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin @(negedge clk); if (o_wr_req) found = 1'b1; end
    n_cmp++; if ({found, o_wr_addr} !== {1'b1, 17'h00000}) begin
      n_err++; $display("FAIL short_rewrite got req=%b addr=%h want req=1 addr=00000", found, o_wr_addr); end
    @(negedge clk); i_clr_status = 1'b1;
    @(negedge clk); i_clr_status = 1'b0;
    n_cmp++; if (o_short_frame !== 1'b0) begin n_err++; $display("FAIL short_clear got=%b want=0", o_short_frame); end
  endtask

  task automatic test_overrun();
    int reqs, dones;
    logic [16:0] last;
    do_reset();
    for (int i = 0; i < FW + 3; i++) push(pat(i));
    i_wr_gnt = 1'b1; reqs = 0; last = '0;
    for (int c = 0; c < FW + 20; c++) begin
      @(negedge clk);
      if (o_wr_req) begin reqs++; last = o_wr_addr; end
    end
    n_cmp++; if (reqs !== FW) begin n_err++; $display("FAIL over_reqs got=%0d want=%0d", reqs, FW); end
    n_cmp++; if (last !== 17'h0998F) begin n_err++; $display("FAIL over_last_addr got=%h want=0998f", last); end
    n_cmp++; if (rp !== wp) begin n_err++; $display("FAIL over_drained got rd=%0d want=%0d", rp, wp); end
    n_cmp++; if ({o_overrun, o_short_frame} !== 2'b10) begin
      n_err++; $display("FAIL over_flags got over/short=%b want 10", {o_overrun, o_short_frame}); end
    i_vsync = 1'b1; dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) i_vsync = 1'b0;
      if (o_frame_done) dones++;
    end
    n_cmp++; if ({dones == 1, o_front_buf, o_frame_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      n_err++; $display("FAIL over_complete got dones=%0d front=%b cnt=%0d want 1/0/1", dones, o_front_buf, o_frame_cnt); end
    i_clr_status = 1'b1;
    @(negedge clk); i_clr_status = 1'b0;
    n_cmp++; if (o_overrun !== 1'b0) begin n_err++; $display("FAIL over_clear got=%b want=0", o_overrun); end
  endtask

  task automatic test_vsync_during_req();
    int bad, nw;
    logic [16:0] wa [4];
    logic [15:0] wd [4];
    do_reset();
    push(16'hA001); push(16'hB002); push(16'hC003);
    @(negedge clk);
    i_vsync = 1'b1; bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 5) i_vsync = 1'b0;
      if (!(o_wr_req === 1'b1 && o_wr_addr === 17'h00000 && o_wr_data === 16'hA001)) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL vs_hold_stable got unstable=%0d want=0", bad); end
    n_cmp++; if (o_short_frame !== 1'b0) begin n_err++; $display("FAIL vs_early_boundary got=%b want=0", o_short_frame); end
    i_wr_gnt = 1'b1; nw = 0;
    for (int i = 0; i < 4; i++) begin wa[i] = '0; wd[i] = '0; end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_wr_req) begin
        if (nw < 4) begin wa[nw] = o_wr_addr; wd[nw] = o_wr_data; end
        nw++;
      end
    end
    i_wr_gnt = 1'b0;
    n_cmp++; if (nw !== 2) begin n_err++; $display("FAIL vs_word_count got=%0d want=2", nw); end
    n_cmp++; if ({wa[0], wd[0], wa[1], wd[1]} !== {17'h00000, 16'hB002, 17'h00001, 16'hC003}) begin
      n_err++; $display("FAIL vs_after_gnt got %h:%h %h:%h want 00000:b002 00001:c003", wa[0], wd[0], wa[1], wd[1]); end
    n_cmp++; if (o_short_frame !== 1'b1) begin n_err++; $display("FAIL vs_boundary_late got=%b want=1", o_short_frame); end
  endtask

  task automatic test_reset_mid_req();
    int nw;
    logic [16:0] wa [4];
    logic [15:0] wd [4];
    do_reset();
    push(16'hD00D); push(16'hE00E); push(16'hF00F);
    @(negedge clk);
    n_cmp++; if (o_wr_req !== 1'b1) begin n_err++; $display("FAIL mid_req_up got=%b want=1", o_wr_req); end
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if ({o_wr_req, o_fifo_rd, o_front_buf} !== 3'b001) begin
      n_err++; $display("FAIL mid_async_drop got req/rd/front=%b want 001", {o_wr_req, o_fifo_rd, o_front_buf}); end
    @(negedge clk); resetn = 1'b1; i_wr_gnt = 1'b1; nw = 0;
    for (int i = 0; i < 4; i++) begin wa[i] = '0; wd[i] = '0; end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_wr_req) begin
        if (nw < 4) begin wa[nw] = o_wr_addr; wd[nw] = o_wr_data; end
        nw++;
      end
    end
    i_wr_gnt = 1'b0;
    n_cmp++; if (nw !== 2) begin n_err++; $display("FAIL mid_word_count got=%0d want=2", nw); end
    n_cmp++; if ({wa[0], wd[0], wa[1], wd[1]} !== {17'h00000, 16'hE00E, 17'h00001, 16'hF00F}) begin
      n_err++; $display("FAIL mid_drain got %h:%h %h:%h want 00000:e00e 00001:f00f", wa[0], wd[0], wa[1], wd[1]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_complete_frame();
    test_short_frame();
    test_overrun();
    test_vsync_during_req();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
